gear_selector_conditioner: RTL and testbench
============================================

Name: gear_selector_conditioner

Overview:
- Input-side front end for the gear-shift FSM: turns the raw, bouncing, asynchronous gear-lever contacts {P,R,N,D} into the clean one-hot 4-bit selector bus the FSM consumes.
- Synchronizes and debounces the lever and validates its one-hot encoding.
- Holds the last legal gear while the lever is between detents, and flags contact faults.
- Sits between the board switches and the FSM's `sw` input.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required before a synchronized vector is accepted (min 2).
- FAULT_CYCLES, 64, consecutive accepted cycles with more than one contact closed before `fault` asserts.
- CNT_W, 8, width of the debounce and fault counters; must hold max(DEBOUNCE_CYCLES, FAULT_CYCLES).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-low
- raw_sw  input  4  raw lever contacts {P,R,N,D}, asynchronous, active-high
- brake  input  1  brake pedal level, asynchronous, active-high
- sw  output  4  clean one-hot gear {P,R,N,D}, drives the FSM
- changed  output  1  one-cycle pulse when `sw` takes a new value
- fault  output  1  multi-contact fault, level
- interlock  output  1  one-cycle pulse when a Park exit is refused

Behaviour:
- Reset: one clock, `clk`; `rst_n` is asynchronous and active-low. While `rst_n`=0:
  - sw=4'b1000 (Park), changed=0, fault=0, interlock=0.
  - Synchronizer flops and counters clear; state=WAIT.
  - Reset mid-operation aborts any debounce or fault count immediately.
- Synchronization: raw_sw and brake each pass through a 2-flop synchronizer; s_sw and s_brake are the second-stage values.
- Debounce:
  - Register prev = s_sw. If s_sw != prev, the counter clears to 0; otherwise it increments, saturating.
  - When the counter reaches DEBOUNCE_CYCLES-1 with s_sw == prev, the vector is accepted as `stable`. It stays accepted each cycle until s_sw changes.
  - Latency from a clean raw_sw edge to a `sw` update: 2 (sync) + DEBOUNCE_CYCLES + 1 (output register) cycles.
- State machine:
  - WAIT: no stable vector. `sw` holds its value. On a stable vector, classify it and go to the matching state below.
  - ONEHOT: stable vector has exactly one bit set.
    - If it differs from `sw` and the interlock permits, update `sw` and pulse `changed` on the same registered edge.
    - Return to WAIT when s_sw changes.
  - GAP: stable vector is 4'b0000 (between detents). `sw` holds, no pulse. Return to WAIT on change.
  - MULTI: stable vector has two or more bits set.
    - `sw` holds, and the fault counter increments each cycle.
    - At FAULT_CYCLES, `fault` sets and stays set.
    - Leaving MULTI clears the fault counter but does not clear `fault`.
- `fault` clears only when a legal one-hot Park vector (4'b1000) is accepted, or on reset.
- While `fault`=1, `sw` is forced to 4'b1000 and `changed` pulses once if `sw` was not already Park.
- Interlock (subject to the Optional Feature):
  - A transition from sw=Park to any other one-hot gear is accepted only if s_brake=1 in the accepting cycle.
  - If s_brake=0: `sw` stays Park, `interlock` pulses once, and the block returns to WAIT only after s_sw changes, so no repeated pulses occur while the lever is held.
  - Transitions into Park and among R/N/D are never blocked.
- Simultaneous events: acceptance and a fault-clearing Park vector in the same cycle both take effect, giving fault=0, sw=Park, and `changed` per the previous `sw`.
- `changed` and `interlock` are never high in the same cycle.

Optional Feature:
- Macro: GEAR_BRAKE_INTERLOCK_EN.
- Defined: the Park-exit brake interlock is active exactly as described in Behaviour.
- Undefined:
  - `brake` is ignored (its synchronizer may be removed) and `interlock` is tied to 0.
  - All one-hot transitions are accepted.
  - The port list is unchanged.

Test Plan:
- Reset then idle: rst_n low for 3 cycles with raw_sw=4'b0100 → sw=4'b1000 and fault=0 during reset. After release, sw=4'b0100 on cycle 2+16+1=19, with changed=1 for that single cycle; with the interlock enabled, hold brake=1.
- Bounce: raw_sw toggles 4'b0010 and 4'b0000 every 5 cycles for 60 cycles, then holds 4'b0010 → sw unchanged during bouncing; sw=4'b0010 exactly 19 cycles after the final edge; one `changed` pulse.
- Gap hold: sw=D (4'b0001), raw_sw=4'b0000 for 200 cycles → sw stays 4'b0001; no changed, fault or interlock.
- Fault: raw_sw=4'b0101 held 100 cycles → fault=1 at cycle 2+16+64 after the edge; sw forced 4'b1000 with one `changed` pulse. Then raw_sw=4'b1000 stable → fault=0.
- Interlock (macro defined): sw=Park, brake=0, raw_sw=4'b0001 stable → one `interlock` pulse, sw stays 4'b1000. Repeat with brake=1 → sw=4'b0001 and changed=1.
- Interlock (macro undefined): same stimulus with brake=0 → sw=4'b0001, interlock stays 0.

Source files
------------

// File: rtl/gear_selector_conditioner.sv
// rtl/gear_selector_conditioner.sv - lever synchronizer, debouncer and one-hot validator for the gear FSM
//
// Purpose:
//   Turns the raw, bouncing gear-lever contacts {P,R,N,D} into a clean one-hot
//   selector bus. Holds the last legal gear between detents, flags multi-contact
//   faults and (optionally) refuses Park exits without the brake applied.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous reset, active-low
//   raw_sw     raw lever contacts {P,R,N,D}, asynchronous, active-high
//   brake      brake pedal level, asynchronous, active-high
//   sw         clean one-hot gear {P,R,N,D}
//   changed    one-cycle pulse when sw takes a new value
//   fault      multi-contact fault, level
//   interlock  one-cycle pulse when a Park exit is refused
//
// Build option:
//   GEAR_BRAKE_INTERLOCK_EN - when defined, leaving Park needs the brake pressed.
//   When undefined, brake is ignored and interlock is always 0.

module gear_selector_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64,
    parameter int CNT_W           = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] raw_sw,
    input  logic       brake,
    output logic [3:0] sw,
    output logic       changed,
    output logic       fault,
    output logic       interlock
);

    localparam logic [3:0]       PARK    = 4'b1000;
    localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLT_MAX = CNT_W'(FAULT_CYCLES);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_ONEHOT,
        ST_GAP,
        ST_MULTI
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic [3:0] sw_meta;
    logic [3:0] s_sw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_meta <= '0;
            s_sw    <= '0;
        end else begin
            sw_meta <= raw_sw;
            s_sw    <= sw_meta;
        end
    end

    logic park_exit_ok;

`ifdef GEAR_BRAKE_INTERLOCK_EN
    logic brake_meta;
    logic s_brake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brake_meta <= 1'b0;
            s_brake    <= 1'b0;
        end else begin
            brake_meta <= brake;
            s_brake    <= brake_meta;
        end
    end

    // Only a move out of Park into another gear needs the brake.
    assign park_exit_ok = (sw != PARK) || (s_sw == PARK) || s_brake;
`else
    logic unused_brake;
    assign unused_brake = brake;
    assign park_exit_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Debounce: count consecutive cycles with an unchanged vector
    // ------------------------------------------------------------------
    logic [3:0]       prev;
    logic [CNT_W-1:0] db_cnt;
    logic             stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev   <= '0;
            db_cnt <= '0;
        end else begin
            prev <= s_sw;
            if (s_sw != prev) begin
                db_cnt <= '0;
            end else if (db_cnt != DEB_MAX) begin
                db_cnt <= db_cnt + CNT_W'(1);
            end
        end
    end

    // The counter saturates at DEB_MAX, so acceptance persists until s_sw moves.
    assign stable = (s_sw == prev) && (db_cnt == DEB_MAX);

    // ------------------------------------------------------------------
    // Vector classification
    // ------------------------------------------------------------------
    logic is_onehot;
    logic is_gap;

    always_comb begin
        is_onehot = 1'b0;
        is_gap    = 1'b0;
        case (s_sw)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: is_onehot = 1'b1;
            4'b0000:                            is_gap    = 1'b1;
            default:                            ;
        endcase
    end

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    state_t           state, state_n;
    logic [3:0]       sw_n;
    logic             changed_n;
    logic             fault_n;
    logic             interlock_n;
    logic [CNT_W-1:0] fault_cnt, fault_cnt_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            sw        <= PARK;
            changed   <= 1'b0;
            fault     <= 1'b0;
            interlock <= 1'b0;
            fault_cnt <= '0;
        end else begin
            state     <= state_n;
            sw        <= sw_n;
            changed   <= changed_n;
            fault     <= fault_n;
            interlock <= interlock_n;
            fault_cnt <= fault_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        sw_n        = sw;
        fault_n     = fault;
        interlock_n = 1'b0;
        fault_cnt_n = '0;

        if (!stable) begin
            state_n = ST_WAIT;
        end else begin
            // Multi-contact time is counted from the first accepted cycle,
            // including the one that classifies the vector out of WAIT.
            if (!is_onehot && !is_gap) begin
                fault_cnt_n = (fault_cnt == FLT_MAX) ? fault_cnt : fault_cnt + CNT_W'(1);
                if (fault_cnt_n == FLT_MAX) begin
                    fault_n = 1'b1;
                end
            end

            // A decision is taken once per stable run; the classified states
            // just wait for the lever to move, so a refused Park exit is not
            // retried or re-pulsed while the lever is held.
            if (state == ST_WAIT) begin
                if (is_onehot) begin
                    state_n = ST_ONEHOT;
                    if (s_sw == PARK) begin
                        fault_n = 1'b0;
                    end
                    if (s_sw != sw) begin
                        if (park_exit_ok) begin
                            sw_n = s_sw;
                        end else begin
                            interlock_n = 1'b1;
                        end
                    end
                end else if (is_gap) begin
                    state_n = ST_GAP;
                end else begin
                    state_n = ST_MULTI;
                end
            end
        end

        // A latched fault pins the selector to Park.
        if (fault_n) begin
            sw_n        = PARK;
            interlock_n = 1'b0;
        end

        changed_n = (sw_n != sw);
    end

endmodule

// File: tb/tb_gear_selector_conditioner.sv
// tb/tb_gear_selector_conditioner.sv - self-checking bench for gear_selector_conditioner

module tb_gear_selector_conditioner;

    localparam int DEB = 16;
    localparam int FLT = 64;
    localparam logic [3:0] PARK = 4'b1000;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw_sw;
    logic       brake;
    logic [3:0] sw;
    logic       changed;
    logic       fault;
    logic       interlock;

    gear_selector_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .FAULT_CYCLES   (FLT),
        .CNT_W          (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_sw   (raw_sw),
        .brake    (brake),
        .sw       (sw),
        .changed  (changed),
        .fault    (fault),
        .interlock(interlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_chg  = 0;
    int n_il   = 0;

    // ------------------------------------------------------------------
    // Reference model: tracks how long the synchronized lever value has
    // been seen unchanged and applies the acceptance rules once per run.
    // ------------------------------------------------------------------
    logic [3:0] m_sync1, m_s;
    logic       m_b1, m_sb;
    int         m_run;
    int         m_mrun;
    logic [3:0] m_sw;
    logic       m_fault, m_changed, m_inter;
    logic [3:0] m_nsw;
    logic       m_nf, m_ni, m_allowed;
    bit         m_stable, m_first, m_onehot, m_multi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync1   = '0;
            m_s       = '0;
            m_b1      = 1'b0;
            m_sb      = 1'b0;
            // The cleared history already matches the cleared synchronized value.
            m_run     = 2;
            m_mrun    = 0;
            m_sw      = PARK;
            m_fault   = 1'b0;
            m_changed = 1'b0;
            m_inter   = 1'b0;
        end else begin
            m_stable = (m_run >= DEB + 1);
            m_first  = (m_run == DEB + 1);
            m_onehot = ($countones(m_s) == 1);
            m_multi  = ($countones(m_s) > 1);
            m_nf  = m_fault;
            m_nsw = m_sw;
            m_ni  = 1'b0;
            if (m_stable && m_multi) begin
                m_mrun++;
                if (m_mrun >= FLT) m_nf = 1'b1;
            end else begin
                m_mrun = 0;
            end
            if (m_first && m_onehot) begin
                if (m_s == PARK) m_nf = 1'b0;
                if (m_s != m_sw) begin
`ifdef GEAR_BRAKE_INTERLOCK_EN
                    m_allowed = !(m_sw == PARK && m_sb == 1'b0);
`else
                    m_allowed = 1'b1;
`endif
                    if (m_allowed) m_nsw = m_s;
                    else           m_ni  = 1'b1;
                end
            end
            if (m_nf) begin
                m_nsw = PARK;
                m_ni  = 1'b0;
            end
            m_changed = (m_nsw != m_sw);
            m_sw      = m_nsw;
            m_fault   = m_nf;
            m_inter   = m_ni;
            m_run     = (m_sync1 == m_s) ? m_run + 1 : 1;
            m_s       = m_sync1;
            m_sync1   = raw_sw;
            m_sb      = m_b1;
            m_b1      = brake;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample after the edge, compare against the model, tally pulses.
    task automatic tick();
        @(posedge clk);
        #3;
        chk("model_sw", sw, m_sw);
        chk("model_changed", changed, m_changed);
        chk("model_fault", fault, m_fault);
        chk("model_interlock", interlock, m_inter);
        n_chg += int'(changed);
        n_il  += int'(interlock);
    endtask

    typedef struct {
        logic [3:0] raw;
        logic       brk;
        int         hold;
        logic [3:0] e_sw;
        logic       e_fault;
        int         e_chg;
        int         e_il;
    } vec_t;

    vec_t tbl[9];

    initial begin
        tbl[0] = '{4'b0001, 1'b0, 30,  4'b0001, 1'b0, 1, 0};
        tbl[1] = '{4'b0000, 1'b0, 200, 4'b0001, 1'b0, 0, 0};
        tbl[2] = '{4'b1000, 1'b0, 30,  4'b1000, 1'b0, 1, 0};
`ifdef GEAR_BRAKE_INTERLOCK_EN
        tbl[3] = '{4'b0001, 1'b0, 30,  4'b1000, 1'b0, 0, 1};
        tbl[4] = '{4'b0000, 1'b1, 30,  4'b1000, 1'b0, 0, 0};
        tbl[5] = '{4'b0001, 1'b1, 30,  4'b0001, 1'b0, 1, 0};
`else
        tbl[3] = '{4'b0001, 1'b0, 30,  4'b0001, 1'b0, 1, 0};
        tbl[4] = '{4'b0000, 1'b1, 30,  4'b0001, 1'b0, 0, 0};
        tbl[5] = '{4'b0001, 1'b1, 30,  4'b0001, 1'b0, 0, 0};
`endif
        tbl[6] = '{4'b0100, 1'b0, 30,  4'b0100, 1'b0, 1, 0};
        tbl[7] = '{4'b1100, 1'b0, 40,  4'b0100, 1'b0, 0, 0};
        tbl[8] = '{4'b0010, 1'b0, 30,  4'b0010, 1'b0, 1, 0};

        rst_n  = 1'b1;
        raw_sw = 4'b0100;
        brake  = 1'b1;
        #1 rst_n = 1'b0;

        // Reset, then first acceptance latency 2 + DEB + 1.
        repeat (3) tick();
        chk("reset_sw", sw, 4'b1000);
        chk("reset_fault", fault, 0);
        chk("reset_changed", changed, 0);
        rst_n = 1'b1;
        n_chg = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 18) chk("reset_lat_before", sw, 4'b1000);
            if (k == 19) begin
                chk("reset_lat_sw", sw, 4'b0100);
                chk("reset_lat_changed", changed, 1);
            end
            if (k == 20) chk("reset_lat_pulse_end", changed, 0);
        end
        chk("reset_lat_pulses", n_chg, 1);

        // Bouncing lever never settles; the final edge is honoured 19 cycles later.
        n_chg = 0;
        for (int i = 0; i < 12; i++) begin
            raw_sw = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            repeat (5) tick();
        end
        chk("bounce_no_change", n_chg, 0);
        chk("bounce_sw_held", sw, 4'b0100);
        raw_sw = 4'b0010;
        for (int k = 1; k <= 19; k++) begin
            tick();
            if (k == 18) chk("bounce_lat_before", sw, 4'b0100);
            if (k == 19) chk("bounce_lat_sw", sw, 4'b0010);
        end
        chk("bounce_pulses", n_chg, 1);

        // Table-driven segments.
        for (int t = 0; t < 9; t++) begin
            raw_sw = tbl[t].raw;
            brake  = tbl[t].brk;
            n_chg  = 0;
            n_il   = 0;
            repeat (tbl[t].hold) tick();
            chk($sformatf("tbl%0d_sw", t), sw, tbl[t].e_sw);
            chk($sformatf("tbl%0d_fault", t), fault, tbl[t].e_fault);
            chk($sformatf("tbl%0d_changed_cnt", t), n_chg, tbl[t].e_chg);
            chk($sformatf("tbl%0d_interlock_cnt", t), n_il, tbl[t].e_il);
        end

        // Multi-contact fault: asserts 2 + DEB + FLT cycles after the edge.
        raw_sw = 4'b0101;
        n_chg  = 0;
        for (int k = 1; k <= 100; k++) begin
            tick();
            if (k == 81) begin
                chk("fault_before", fault, 0);
                chk("fault_sw_before", sw, 4'b0010);
            end
            if (k == 82) begin
                chk("fault_set", fault, 1);
                chk("fault_sw_park", sw, 4'b1000);
                chk("fault_changed", changed, 1);
            end
        end
        chk("fault_pulses", n_chg, 1);
        raw_sw = 4'b1000;
        n_chg  = 0;
        repeat (30) tick();
        chk("fault_cleared", fault, 0);
        chk("fault_clear_sw", sw, 4'b1000);
        chk("fault_clear_no_pulse", n_chg, 0);

        // Randomized segments against the model, with occasional mid-run resets.
        for (int seg = 0; seg < 150; seg++) begin
            int sel;
            int hold;
            sel = $urandom_range(0, 5);
            case (sel)
                0: raw_sw = 4'b1000;
                1: raw_sw = 4'b0100;
                2: raw_sw = 4'b0010;
                3: raw_sw = 4'b0001;
                4: raw_sw = 4'b0000;
                default: raw_sw = 4'($urandom_range(0, 15));
            endcase
            brake = 1'($urandom_range(0, 1));
            hold  = ($urandom_range(0, 9) == 0) ? 90 : $urandom_range(1, 30);
            repeat (hold) tick();
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                repeat (2) tick();
                rst_n = 1'b1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
